// File: rtl/amber48_pkg.sv
// Shared types and constants for the amber48 core memory-side blocks.
package amber48_pkg;

    localparam int XLEN                   = 32;
    localparam int ARB_STARVE_MAX_DEFAULT = 4;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_FETCH_REQ,
        ARB_DATA_REQ,
        ARB_FETCH_WAIT,
        ARB_DATA_WAIT
    } amber48_arb_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } amber48_mem_req_s;

endpackage

// File: rtl/amber48_arb_perf_counters.sv
// Wrapping event counters for the memory arbiter (fetch delivered, data delivered, fetch dropped).
module amber48_arb_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clk_en_i,
    input  logic [2:0]       inc_i,
    output logic [CNT_W-1:0] perf_fetch_o,
    output logic [CNT_W-1:0] perf_data_o,
    output logic [CNT_W-1:0] perf_drop_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else if (clk_en_i && inc_i[gi]) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    assign perf_fetch_o = g_cnt[0].cnt_q;
    assign perf_data_o  = g_cnt[1].cnt_q;
    assign perf_drop_o  = g_cnt[2].cnt_q;

endmodule

// File: rtl/amber48_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data, data first with a
// fetch starvation guard. Define AMBER48_ARB_PERF_EN to add the perf_* counter outputs.
module amber48_mem_arbiter
    import amber48_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT
`ifdef AMBER48_ARB_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clk_en_i,
    input  logic [XLEN-1:0]  imem_addr_i,
    output logic [XLEN-1:0]  imem_data_o,
    output logic             imem_valid_o,
    output logic             fetch_fault_o,
    input  logic             dmem_req_i,
    input  logic             dmem_we_i,
    input  logic [XLEN-1:0]  dmem_addr_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    output logic [XLEN-1:0]  dmem_rdata_o,
    output logic             dmem_ready_o,
    output logic             dmem_trap_o,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic             mem_err_i
`ifdef AMBER48_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_fetch_o,
    output logic [CNT_W-1:0] perf_data_o,
    output logic [CNT_W-1:0] perf_drop_o
`endif
);

    localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);

    amber48_arb_state_e state_q, state_d;
    logic [3:0]         data_streak_q, data_streak_d;
    logic [XLEN-1:0]    fetch_addr_q, fetch_addr_d;
    amber48_mem_req_s   req_q, req_d;

    logic rsp_data;
    logic rsp_fetch;
    logic fetch_match;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ARB_IDLE;
            data_streak_q <= '0;
            fetch_addr_q  <= '0;
            req_q         <= '0;
        end else if (clk_en_i) begin
            state_q       <= state_d;
            data_streak_q <= data_streak_d;
            fetch_addr_q  <= fetch_addr_d;
            req_q         <= req_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        data_streak_d = data_streak_q;
        fetch_addr_d  = fetch_addr_q;
        req_d         = req_q;
        case (state_q)
            ARB_IDLE: begin
                // Fetch is always wanted, so the streak counts data grants made while it waited.
                if (dmem_req_i && (data_streak_q < STREAK_LIM)) begin
                    state_d = ARB_DATA_REQ;
                    req_d   = '{we: dmem_we_i, addr: dmem_addr_i, wdata: dmem_wdata_i};
                    if (data_streak_q != 4'hF) begin
                        data_streak_d = data_streak_q + 4'd1;
                    end
                end else begin
                    state_d       = ARB_FETCH_REQ;
                    fetch_addr_d  = imem_addr_i;
                    data_streak_d = '0;
                end
            end
            ARB_FETCH_REQ:  if (mem_ready_i)  state_d = ARB_FETCH_WAIT;
            ARB_DATA_REQ:   if (mem_ready_i)  state_d = ARB_DATA_WAIT;
            ARB_FETCH_WAIT: if (mem_rvalid_i) state_d = ARB_IDLE;
            ARB_DATA_WAIT:  if (mem_rvalid_i) state_d = ARB_IDLE;
            default:        state_d = ARB_IDLE;
        endcase
    end

    assign mem_valid_o = (state_q == ARB_FETCH_REQ) || (state_q == ARB_DATA_REQ);
    assign mem_we_o    = (state_q == ARB_DATA_REQ) && req_q.we;
    assign mem_addr_o  = (state_q == ARB_FETCH_REQ) ? fetch_addr_q :
                         (state_q == ARB_DATA_REQ)  ? req_q.addr   : '0;
    assign mem_wdata_o = (state_q == ARB_DATA_REQ) ? req_q.wdata : '0;

    // Responses are steered combinationally; every output is zero outside its response cycle.
    assign rsp_data    = (state_q == ARB_DATA_WAIT) && mem_rvalid_i;
    assign rsp_fetch   = (state_q == ARB_FETCH_WAIT) && mem_rvalid_i;
    assign fetch_match = rsp_fetch && (imem_addr_i == fetch_addr_q);

    assign dmem_ready_o  = rsp_data;
    assign dmem_rdata_o  = rsp_data ? mem_rdata_i : '0;
    assign dmem_trap_o   = rsp_data && mem_err_i;

    assign imem_valid_o  = fetch_match && !mem_err_i;
    assign imem_data_o   = imem_valid_o ? mem_rdata_i : '0;
    assign fetch_fault_o = fetch_match && mem_err_i;

`ifdef AMBER48_ARB_PERF_EN
    amber48_arb_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clk_en_i    (clk_en_i),
        .inc_i       ({rsp_fetch && !fetch_match, rsp_data, fetch_match}),
        .perf_fetch_o(perf_fetch_o),
        .perf_data_o (perf_data_o),
        .perf_drop_o (perf_drop_o)
    );
`endif

endmodule

// File: tb/tb_amber48_mem_arbiter.sv
// Bench for amber48_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_amber48_mem_arbiter;
    import amber48_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni, clk_en_i;
    logic [31:0] imem_addr_i, imem_data_o;
    logic        imem_valid_o, fetch_fault_o;
    logic        dmem_req_i, dmem_we_i;
    logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
    logic        dmem_ready_o, dmem_trap_o;
    logic        mem_valid_o, mem_ready_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_rvalid_i, mem_err_i;
`ifdef AMBER48_ARB_PERF_EN
    logic [31:0] perf_fetch_o, perf_data_o, perf_drop_o;
`endif

    always #5 clk_i = ~clk_i;

    amber48_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clk_en_i(clk_en_i),
        .imem_addr_i(imem_addr_i), .imem_data_o(imem_data_o),
        .imem_valid_o(imem_valid_o), .fetch_fault_o(fetch_fault_o),
        .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_rdata_o(dmem_rdata_o),
        .dmem_ready_o(dmem_ready_o), .dmem_trap_o(dmem_trap_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
`ifdef AMBER48_ARB_PERF_EN
        , .perf_fetch_o(perf_fetch_o), .perf_data_o(perf_data_o), .perf_drop_o(perf_drop_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding transfer, either a data or a fetch.
    bit          m_act, m_acc, m_data, m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_streak;

    always @(negedge clk_i) begin : model_cmp
        logic [31:0] e_addr, e_wdata, e_drdata, e_idata;
        logic        e_mv, e_we, e_drdy, e_trap, e_ival, e_fault, resp, fhit;
        if (!rst_ni) begin
            m_act = 0; m_acc = 0; m_streak = 0;
            e_mv = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_drdy = 0; e_drdata = 0; e_trap = 0; e_ival = 0; e_idata = 0; e_fault = 0;
        end else begin
            e_mv     = m_act && !m_acc;
            e_we     = e_mv && m_data && m_we;
            e_addr   = e_mv ? m_addr : 32'h0;
            e_wdata  = (e_mv && m_data) ? m_wdata : 32'h0;
            resp     = m_act && m_acc && mem_rvalid_i;
            e_drdy   = resp && m_data;
            e_drdata = e_drdy ? mem_rdata_i : 32'h0;
            e_trap   = e_drdy && mem_err_i;
            fhit     = resp && !m_data && (imem_addr_i == m_addr);
            e_ival   = fhit && !mem_err_i;
            e_idata  = e_ival ? mem_rdata_i : 32'h0;
            e_fault  = fhit && mem_err_i;
            chk1("proto_rvalid", mem_rvalid_i && !(m_act && m_acc), 1'b0);
            if (clk_en_i) begin
                if (!m_act) begin
                    m_act = 1; m_acc = 0;
                    if (dmem_req_i && m_streak < STARVE_MAX) begin
                        m_data = 1; m_we = dmem_we_i; m_addr = dmem_addr_i; m_wdata = dmem_wdata_i;
                        if (m_streak < 15) m_streak++;
                    end else begin
                        m_data = 0; m_we = 0; m_addr = imem_addr_i; m_wdata = 0;
                        m_streak = 0;
                    end
                end else if (!m_acc) begin
                    if (mem_ready_i) m_acc = 1;
                end else if (mem_rvalid_i) begin
                    m_act = 0;
                end
            end
        end
        chk1("m_mem_valid", mem_valid_o, e_mv);
        chk1("m_mem_we", mem_we_o, e_we);
        chk32("m_mem_addr", mem_addr_o, e_addr);
        chk32("m_mem_wdata", mem_wdata_o, e_wdata);
        chk1("m_dmem_ready", dmem_ready_o, e_drdy);
        chk32("m_dmem_rdata", dmem_rdata_o, e_drdata);
        chk1("m_dmem_trap", dmem_trap_o, e_trap);
        chk1("m_imem_valid", imem_valid_o, e_ival);
        chk32("m_imem_data", imem_data_o, e_idata);
        chk1("m_fetch_fault", fetch_fault_o, e_fault);
    end

    // Stimulus side: memory responder and core traffic, all driven from one process.
    bit auto_mem = 0, rnd = 0, pend = 0, dmem_ack = 0;
    int lat = 0;
    bit grants[$];

    // Called right after a negedge: samples handshakes, then drives the next cycle at posedge+1.
    task automatic step();
        bit acc;
        acc      = mem_valid_o && mem_ready_i && clk_en_i && rst_ni;
        dmem_ack = dmem_ready_o;
        if (acc) grants.push_back(mem_addr_o == 32'h200);
        @(posedge clk_i);
        #1;
        if (auto_mem) begin
            mem_rvalid_i = 0;
            mem_rdata_i  = $urandom;
            mem_err_i    = ($urandom_range(0, 7) == 0);
            clk_en_i     = rnd ? ($urandom_range(0, 99) < 85) : 1'b1;
            mem_ready_i  = rnd ? ($urandom_range(0, 99) < 60) : 1'b1;
            if (!rst_ni) begin
                pend = 0;
            end else begin
                if (acc) begin
                    pend = 1;
                    lat  = rnd ? $urandom_range(0, 3) : 0;
                end
                if (pend && clk_en_i) begin
                    if (lat == 0) begin
                        mem_rvalid_i = 1; pend = 0;
                    end else begin
                        lat--;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
        step();
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int rst_cnt;
        bit exp_pat[10];
        exp_pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        rst_ni = 0; clk_en_i = 1; imem_addr_i = 32'h30;
        dmem_req_i = 0; dmem_we_i = 0; dmem_addr_i = 0; dmem_wdata_i = 0;
        mem_ready_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF; mem_err_i = 1;

        // Reset with a spurious response on the bus: everything must stay 0.
        repeat (3) begin
            @(negedge clk_i);
            chk1("rst_mem_valid", mem_valid_o, 1'b0);
            chk1("rst_imem_valid", imem_valid_o, 1'b0);
            chk1("rst_dmem_ready", dmem_ready_o, 1'b0);
            chk32("rst_dmem_rdata", dmem_rdata_o, 32'h0);
            chk1("rst_fetch_fault", fetch_fault_o, 1'b0);
            step();
        end
        rst_ni = 1; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;

        // Fetch at 0x30
        @(negedge clk_i); chk1("t1_idle", mem_valid_o, 1'b0); step();
        @(negedge clk_i); chk1("t1_req", mem_valid_o, 1'b1); chk32("t1_addr", mem_addr_o, 32'h30);
        chk1("t1_we", mem_we_o, 1'b0); step();
        mem_rvalid_i = 1; mem_rdata_i = 32'hABCD;
        @(negedge clk_i); chk1("t1_ivalid", imem_valid_o, 1'b1); chk32("t1_idata", imem_data_o, 32'hABCD);
        chk1("t1_fault", fetch_fault_o, 1'b0); step();

        // Load 0x100 returning an error
        mem_rvalid_i = 0; dmem_req_i = 1; dmem_we_i = 0; dmem_addr_i = 32'h100;
        @(negedge clk_i); chk1("t2_idle", mem_valid_o, 1'b0); step();
        @(negedge clk_i); chk32("t2_addr", mem_addr_o, 32'h100); chk1("t2_req", mem_valid_o, 1'b1); step();
        mem_rvalid_i = 1; mem_rdata_i = 32'h55; mem_err_i = 1;
        @(negedge clk_i); chk1("t2_ready", dmem_ready_o, 1'b1); chk1("t2_trap", dmem_trap_o, 1'b1);
        chk32("t2_rdata", dmem_rdata_o, 32'h55); step();
        mem_rvalid_i = 0; mem_err_i = 0; dmem_req_i = 0;
        @(negedge clk_i); chk1("t2_back_idle", mem_valid_o, 1'b0); chk1("t2_ready_low", dmem_ready_o, 1'b0); step();

        // Stale fetch: PC moves from 0x30 to 0x60 before the response
        @(negedge clk_i); chk32("t3_addr", mem_addr_o, 32'h30); step();
        imem_addr_i = 32'h60; mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
        @(negedge clk_i); chk1("t3_ivalid", imem_valid_o, 1'b0); chk1("t3_fault", fetch_fault_o, 1'b0);
        chk32("t3_idata", imem_data_o, 32'h0); step();
        mem_rvalid_i = 0;
        @(negedge clk_i);
`ifdef AMBER48_ARB_PERF_EN
        chk32("t3_perf_drop", perf_drop_o, 32'd1);
        chk32("t3_perf_fetch", perf_fetch_o, 32'd1);
        chk32("t3_perf_data", perf_data_o, 32'd1);
`endif
        step();
        @(negedge clk_i); chk32("t3_refetch", mem_addr_o, 32'h60); step();
        mem_rvalid_i = 1; mem_rdata_i = 32'h600D;
        @(negedge clk_i); chk32("t3_idata2", imem_data_o, 32'h600D); step();

        // Backpressure on a store
        mem_rvalid_i = 0; mem_ready_i = 0;
        dmem_req_i = 1; dmem_we_i = 1; dmem_addr_i = 32'h104; dmem_wdata_i = 32'hDEADBEEF;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk1("t5_valid", mem_valid_o, 1'b1); chk32("t5_addr", mem_addr_o, 32'h104);
            chk32("t5_wdata", mem_wdata_o, 32'hDEADBEEF); chk1("t5_we", mem_we_o, 1'b1);
            chk1("t5_noready", dmem_ready_o, 1'b0);
            step();
        end
        mem_ready_i = 1;
        cyc();
        mem_rvalid_i = 1; mem_rdata_i = 32'h0;
        @(negedge clk_i); chk1("t5_wr_ready", dmem_ready_o, 1'b1); chk1("t5_trap", dmem_trap_o, 1'b0); step();

        // Clock enable low in DATA_REQ with memory ready
        mem_rvalid_i = 0; dmem_we_i = 0; dmem_addr_i = 32'h108; dmem_wdata_i = 0;
        cyc();
        clk_en_i = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i); chk1("t6_hold_valid", mem_valid_o, 1'b1); chk32("t6_hold_addr", mem_addr_o, 32'h108);
            step();
        end
        clk_en_i = 1;
        @(negedge clk_i); chk1("t6_req", mem_valid_o, 1'b1); step();
        @(negedge clk_i); chk1("t6_wait", mem_valid_o, 1'b0); chk1("t6_wait_rdy", dmem_ready_o, 1'b0); step();
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        @(negedge clk_i); chk1("t6_ready", dmem_ready_o, 1'b1); chk32("t6_rdata", dmem_rdata_o, 32'h77); step();
        mem_rvalid_i = 0; dmem_req_i = 0;

        // Starvation guard with data requested continuously
        rst_ni = 0;
        cyc(); cyc();
        auto_mem = 1; rnd = 0; imem_addr_i = 32'h40;
        dmem_req_i = 1; dmem_we_i = 0; dmem_addr_i = 32'h200;
        grants.delete();
        rst_ni = 1;
        for (int i = 0; i < 200 && grants.size() < 10; i++) cyc();
        chk32("t4_grant_count", 32'(grants.size()), 32'd10);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            chk1($sformatf("t4_grant%0d", i), grants[i], exp_pat[i]);

        // Randomized traffic with clock-enable gaps, PC redirects and mid-transfer resets
        rnd = 1; rst_ni = 0; rst_cnt = 2;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_ni = 1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_ni = 0; rst_cnt = 2;
            end
            if (!dmem_req_i || dmem_ack) begin
                dmem_req_i   = $urandom_range(0, 1);
                dmem_we_i    = $urandom_range(0, 1);
                dmem_addr_i  = 32'($urandom_range(0, 15)) << 2;
                dmem_wdata_i = $urandom;
            end
            if ($urandom_range(0, 9) == 0) imem_addr_i = 32'($urandom_range(0, 7)) << 2;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
